// File: rtl/rst_sequencer_if.sv
// Lock inputs, software request and sequenced reset outputs shared between
// the reset sequencer and the clocking fabric around it.
interface rst_sequencer_if #(
  parameter int NUM_LOCK = 3,
  parameter int NUM_CH   = 4
);
  logic [NUM_LOCK-1:0] lock_i;
  logic                sw_rst_i;
  logic                pll_rst_o;
  logic [NUM_CH-1:0]   rst_o;
  logic                done_o;
  logic [1:0]          state_o;
  logic [7:0]          relock_cnt_o;
  logic [7:0]          timeout_cnt_o;

  modport master (
    output lock_i, sw_rst_i,
    input  pll_rst_o, rst_o, done_o, state_o, relock_cnt_o, timeout_cnt_o
  );

  modport slave (
    input  lock_i, sw_rst_i,
    output pll_rst_o, rst_o, done_o, state_o, relock_cnt_o, timeout_cnt_o
  );
endinterface

// File: rtl/rst_sequencer.sv
// Lock-qualified reset sequencer: holds the PLLs in reset, waits for a filtered
// lock, then releases the channel resets one by one and re-arms on lock loss.
module rst_sequencer #(
  parameter int NUM_LOCK     = 3,
  parameter int NUM_CH       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_FILTER  = 16,
  parameter int LOSS_FILTER  = 4,
  parameter int RELEASE_GAP  = 8,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int PLL_RST_LEN  = 32
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  rst_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int PW = $clog2(PLL_RST_LEN) + 1;
  localparam int FW = $clog2(LOCK_FILTER) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int GW = $clog2(RELEASE_GAP) + 1;
  localparam int LW = $clog2(LOSS_FILTER) + 1;

  localparam logic [PW-1:0] PLL_LAST  = PW'(PLL_RST_LEN - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(RELEASE_GAP - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_FILTER - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [NUM_LOCK-1:0] lock_sync_r [SYNC_STAGES];
  logic                locked_s;

  state_t            state_r, state_s;
  logic [PW-1:0]     pll_cnt_r, pll_cnt_s;
  logic [FW-1:0]     filt_cnt_r, filt_cnt_s;
  logic [TW-1:0]     tmo_cnt_r, tmo_cnt_s;
  logic [GW-1:0]     gap_cnt_r, gap_cnt_s;
  logic [LW-1:0]     loss_cnt_r, loss_cnt_s, loss_next_s;
  logic [NUM_CH-1:0] rst_r, rst_s, rst_shift_s;
  logic [7:0]        relock_r, relock_s;
  logic [7:0]        timeout_r, timeout_s;
  logic              done_r, pll_rst_r;
  logic              loss_hit_s, filt_hit_s;

  // Bring the asynchronous lock flags into the wb_clk_i domain.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) lock_sync_r[i] <= '0;
    end else begin
      lock_sync_r[0] <= bus.lock_i;
      for (int i = 1; i < SYNC_STAGES; i++) lock_sync_r[i] <= lock_sync_r[i-1];
    end
  end

  assign locked_s    = &lock_sync_r[SYNC_STAGES-1];
  assign filt_hit_s  = locked_s && (filt_cnt_r == FILT_LAST);
  assign loss_hit_s  = !locked_s && (loss_cnt_r == LOSS_LAST);
  assign loss_next_s = locked_s ? '0 : loss_cnt_r + 1'b1;
  assign rst_shift_s = rst_r << 1'b1;

  // Next-state and next-output decode; software request overrides everything.
  always_comb begin
    state_s    = state_r;
    pll_cnt_s  = pll_cnt_r;
    filt_cnt_s = filt_cnt_r;
    tmo_cnt_s  = tmo_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    loss_cnt_s = loss_cnt_r;
    rst_s      = rst_r;
    relock_s   = relock_r;
    timeout_s  = timeout_r;
    if (bus.sw_rst_i) begin
      state_s   = ST_PLL_RST;
      pll_cnt_s = '0;
      rst_s     = '1;
    end else begin
      case (state_r)
        ST_PLL_RST: begin
          rst_s = '1;
          if (pll_cnt_r == PLL_LAST) begin
            state_s    = ST_WAIT_LOCK;
            filt_cnt_s = '0;
            tmo_cnt_s  = '0;
          end else begin
            pll_cnt_s = pll_cnt_r + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          rst_s = '1;
          if (filt_hit_s) begin
            state_s    = ST_RELEASE;
            rst_s      = {NUM_CH{1'b1}} << 1'b1;
            gap_cnt_s  = '0;
            loss_cnt_s = '0;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_s   = ST_PLL_RST;
            pll_cnt_s = '0;
            timeout_s = sat_inc8(timeout_r);
          end else begin
            filt_cnt_s = locked_s ? filt_cnt_r + 1'b1 : '0;
            tmo_cnt_s  = tmo_cnt_r + 1'b1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (loss_hit_s) begin
            state_s    = ST_WAIT_LOCK;
            rst_s      = '1;
            relock_s   = sat_inc8(relock_r);
            filt_cnt_s = '0;
            tmo_cnt_s  = '0;
            loss_cnt_s = '0;
          end else begin
            loss_cnt_s = loss_next_s;
            if (state_r == ST_RUN) begin
              state_s = ST_RUN;
            end else if (rst_r == '0) begin
              // single-channel build: first release cycle already cleared everything
              state_s = ST_RUN;
            end else if (gap_cnt_r == GAP_LAST) begin
              rst_s     = rst_shift_s;
              gap_cnt_s = '0;
              state_s   = (rst_shift_s == '0) ? ST_RUN : ST_RELEASE;
            end else begin
              gap_cnt_s = gap_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_s   = ST_PLL_RST;
          pll_cnt_s = '0;
          rst_s     = '1;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= ST_PLL_RST;
      pll_cnt_r  <= '0;
      filt_cnt_r <= '0;
      tmo_cnt_r  <= '0;
      gap_cnt_r  <= '0;
      loss_cnt_r <= '0;
      rst_r      <= '1;
      relock_r   <= 8'd0;
      timeout_r  <= 8'd0;
      done_r     <= 1'b0;
      pll_rst_r  <= 1'b1;
    end else begin
      state_r    <= state_s;
      pll_cnt_r  <= pll_cnt_s;
      filt_cnt_r <= filt_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      loss_cnt_r <= loss_cnt_s;
      rst_r      <= rst_s;
      relock_r   <= relock_s;
      timeout_r  <= timeout_s;
      done_r     <= ~|rst_s;
      pll_rst_r  <= (state_s == ST_PLL_RST);
    end
  end

  assign bus.pll_rst_o     = pll_rst_r;
  assign bus.rst_o         = rst_r;
  assign bus.done_o        = done_r;
  assign bus.state_o       = state_r;
  assign bus.relock_cnt_o  = relock_r;
  assign bus.timeout_cnt_o = timeout_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: a phase/elapsed-time model is compared every
// cycle, and hand-computed cycle numbers pin both the model and the design.
module tb_rst_sequencer;
  localparam int NUM_LOCK     = 3;
  localparam int NUM_CH       = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int LOCK_FILTER  = 16;
  localparam int LOSS_FILTER  = 4;
  localparam int RELEASE_GAP  = 8;
  localparam int LOCK_TIMEOUT = 200;
  localparam int PLL_RST_LEN  = 32;
  localparam int LAST_REL     = ((NUM_CH - 1) * RELEASE_GAP > 0) ? (NUM_CH - 1) * RELEASE_GAP : 1;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;

  rst_sequencer_if #(.NUM_LOCK(NUM_LOCK), .NUM_CH(NUM_CH)) bus ();

  rst_sequencer #(
    .NUM_LOCK(NUM_LOCK), .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES),
    .LOCK_FILTER(LOCK_FILTER), .LOSS_FILTER(LOSS_FILTER), .RELEASE_GAP(RELEASE_GAP),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .PLL_RST_LEN(PLL_RST_LEN)
  ) dut (
    .wb_clk_i (wb_clk),
    .wb_rst_i (wb_rst),
    .bus      (bus)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: phase 0..3, cycles spent in phase, run lengths of lock/unlock, release elapsed time.
  int m_phase, m_age, m_lockrun, m_lossrun, m_rel, m_relock, m_tmo;
  bit m_valid = 1'b0;
  bit lk_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_rst();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = (m_phase < 2) || (m_rel < k * RELEASE_GAP);
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit lk, input bit sw);
    bit locked;
    if (rst) begin
      m_phase = 0; m_age = 0; m_lockrun = 0; m_lossrun = 0; m_rel = 0;
      m_relock = 0; m_tmo = 0; cyc = 0; m_valid = 1'b1;
      lk_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) lk_q.push_back(1'b0);
      return;
    end
    locked = lk_q.pop_front();
    lk_q.push_back(lk);
    cyc++;
    if (sw) begin
      m_phase = 0; m_age = 0;
      return;
    end
    case (m_phase)
      0: begin
        m_age++;
        if (m_age == PLL_RST_LEN) begin m_phase = 1; m_age = 0; m_lockrun = 0; end
      end
      1: begin
        m_age++;
        m_lockrun = locked ? m_lockrun + 1 : 0;
        if (m_lockrun == LOCK_FILTER) begin
          m_phase = 2; m_rel = 0; m_lossrun = 0;
        end else if (m_age == LOCK_TIMEOUT) begin
          m_phase = 0; m_age = 0;
          if (m_tmo < 255) m_tmo++;
        end
      end
      default: begin
        m_lossrun = locked ? 0 : m_lossrun + 1;
        if (m_lossrun == LOSS_FILTER) begin
          m_phase = 1; m_age = 0; m_lockrun = 0;
          if (m_relock < 255) m_relock++;
        end else if (m_phase == 2) begin
          m_rel++;
          if (m_rel >= LAST_REL) m_phase = 3;
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge wb_clk);
    model_step(wb_rst, &bus.lock_i, bus.sw_rst_i);
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge wb_clk);
    if (m_valid) begin
      check("state_o", bus.state_o, m_phase);
      check("pll_rst_o", bus.pll_rst_o, (m_phase == 0));
      check("rst_o", bus.rst_o, exp_rst());
      check("done_o", bus.done_o, (exp_rst() == '0));
      check("relock_cnt_o", bus.relock_cnt_o, m_relock);
      check("timeout_cnt_o", bus.timeout_cnt_o, m_tmo);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic go_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 100000) begin tick(); guard++; end
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    int n = 0;
    while (bus.state_o !== s[1:0] && n < budget) begin tick(); n++; end
    check(name, bus.state_o, s);
  endtask

  task automatic do_reset(input logic [NUM_LOCK-1:0] lk);
    wb_rst = 1'b1;
    bus.lock_i = lk;
    bus.sw_rst_i = 1'b0;
    repeat (3) tick();
    wb_rst = 1'b0;
  endtask

  task automatic pin(input string name, input int s, input bit pll, input logic [NUM_CH-1:0] r);
    check({name, "_state"}, bus.state_o, s);
    check({name, "_pll"}, bus.pll_rst_o, pll);
    check({name, "_rst"}, bus.rst_o, r);
  endtask

  initial begin
    bus.lock_i   = '0;
    bus.sw_rst_i = 1'b0;
    do_reset(3'b111);

    // T1: staged release with lock present from the start
    pin("t1_c0", 0, 1'b1, 4'hF);
    check("t1_c0_done", bus.done_o, 1'b0);
    check("t1_c0_relock", bus.relock_cnt_o, 8'd0);
    check("t1_c0_tmo", bus.timeout_cnt_o, 8'd0);
    go_to(31); pin("t1_c31", 0, 1'b1, 4'hF);
    go_to(32); pin("t1_c32", 1, 1'b0, 4'hF);
    go_to(47); pin("t1_c47", 1, 1'b0, 4'hF);
    go_to(48); pin("t1_c48", 2, 1'b0, 4'hE);
    go_to(56); pin("t1_c56", 2, 1'b0, 4'hC);
    go_to(64); pin("t1_c64", 2, 1'b0, 4'h8);
    go_to(71); check("t1_c71_done", bus.done_o, 1'b0);
    go_to(72); pin("t1_c72", 3, 1'b0, 4'h0);
    check("t1_c72_done", bus.done_o, 1'b1);

    // T3: 3-cycle dropout ignored, 4-cycle dropout re-arms and re-sequences
    go_to(80);  bus.lock_i = 3'b101;
    go_to(83);  bus.lock_i = 3'b111;
    go_to(90);  pin("t3_short", 3, 1'b0, 4'h0);
    check("t3_short_relock", bus.relock_cnt_o, 8'd0);
    go_to(100); bus.lock_i = 3'b101;
    go_to(104); bus.lock_i = 3'b111;
    go_to(105); pin("t3_c105", 3, 1'b0, 4'h0);
    go_to(106); pin("t3_c106", 1, 1'b0, 4'hF);
    check("t3_c106_relock", bus.relock_cnt_o, 8'd1);
    check("t3_c106_done", bus.done_o, 1'b0);
    go_to(122); pin("t3_c122", 2, 1'b0, 4'hE);
    go_to(146); pin("t3_c146", 3, 1'b0, 4'h0);

    // T5: software request coincides with the 4th unlocked cycle
    go_to(160); bus.lock_i = 3'b101;
    go_to(164); bus.lock_i = 3'b111;
    go_to(165); pin("t5_c165", 3, 1'b0, 4'h0);
    bus.sw_rst_i = 1'b1;
    go_to(166); bus.sw_rst_i = 1'b0;
    pin("t5_c166", 0, 1'b1, 4'hF);
    check("t5_c166_relock", bus.relock_cnt_o, 8'd1);
    go_to(214); pin("t5_c214", 2, 1'b0, 4'hE);

    // T4: software request mid-release
    go_to(225); pin("t4_c225", 2, 1'b0, 4'hC);
    bus.sw_rst_i = 1'b1;
    go_to(226); bus.sw_rst_i = 1'b0;
    pin("t4_c226", 0, 1'b1, 4'hF);
    go_to(257); pin("t4_c257", 0, 1'b1, 4'hF);
    go_to(258); pin("t4_c258", 1, 1'b0, 4'hF);
    go_to(274); pin("t4_c274", 2, 1'b0, 4'hE);

    // T6: drive relock counter into saturation
    for (int i = 0; i < 256; i++) begin
      wait_state("t6_release", 2, 100);
      bus.lock_i = 3'b110;
      repeat (4) tick();
      bus.lock_i = 3'b111;
      wait_state("t6_rearm", 1, 20);
      check("t6_relock", bus.relock_cnt_o, (i + 2 > 255) ? 255 : i + 2);
    end
    check("t6_relock_sat", bus.relock_cnt_o, 8'd255);

    // wb_rst_i mid-release restores every reset value
    wait_state("t6_last_release", 2, 100);
    repeat (8) tick();
    check("t6_rst_mid", bus.rst_o, 4'hC);
    wb_rst = 1'b1;
    tick();
    pin("t6_wbrst", 0, 1'b1, 4'hF);
    check("t6_wbrst_done", bus.done_o, 1'b0);
    check("t6_wbrst_relock", bus.relock_cnt_o, 8'd0);
    check("t6_wbrst_tmo", bus.timeout_cnt_o, 8'd0);

    // T2: no lock ever -> periodic PLL retry, timeout counter steps
    do_reset(3'b000);
    go_to(32);  pin("t2_c32", 1, 1'b0, 4'hF);
    go_to(231); pin("t2_c231", 1, 1'b0, 4'hF);
    check("t2_c231_tmo", bus.timeout_cnt_o, 8'd0);
    go_to(232); pin("t2_c232", 0, 1'b1, 4'hF);
    check("t2_c232_tmo", bus.timeout_cnt_o, 8'd1);
    go_to(263); pin("t2_c263", 0, 1'b1, 4'hF);
    go_to(264); pin("t2_c264", 1, 1'b0, 4'hF);
    go_to(463); check("t2_c463_tmo", bus.timeout_cnt_o, 8'd1);
    go_to(464); pin("t2_c464", 0, 1'b1, 4'hF);
    check("t2_c464_tmo", bus.timeout_cnt_o, 8'd2);

    // Filter completes on the same cycle as the timeout: release wins
    do_reset(3'b000);
    go_to(214); bus.lock_i = 3'b111;
    go_to(231); pin("tie_c231", 1, 1'b0, 4'hF);
    go_to(232); pin("tie_c232", 2, 1'b0, 4'hE);
    check("tie_c232_tmo", bus.timeout_cnt_o, 8'd0);
    go_to(256); pin("tie_c256", 3, 1'b0, 4'h0);
    check("tie_c256_done", bus.done_o, 1'b1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
